// File: rtl/first_nios2_sysid_pkg.sv
// Shared register map, CTRL bit positions and INFO field layout for the
// extended sysid/housekeeping slave.
package first_nios2_sysid_pkg;

  // Word offsets of the register map
  localparam int unsigned SYSID_OFS     = 0;
  localparam int unsigned TSTAMP_OFS    = 1;
  localparam int unsigned INFO_OFS      = 2;
  localparam int unsigned CTRL_OFS      = 3;
  localparam int unsigned UPTIME_LO_OFS = 4;
  localparam int unsigned UPTIME_HI_OFS = 5;
  localparam int unsigned SCRATCH_BASE  = 6;

  // CTRL register bits
  localparam int unsigned CTRL_CNT_EN_BIT  = 0;
  localparam int unsigned CTRL_CNT_CLR_BIT = 1;

  // INFO field positions
  localparam int unsigned INFO_VERSION_LSB  = 0;
  localparam int unsigned INFO_NSCRATCH_LSB = 8;
  localparam int unsigned INFO_CLK_MHZ_LSB  = 16;

  function automatic logic [31:0] pack_info(input logic [7:0]  version,
                                            input logic [7:0]  nscratch,
                                            input logic [15:0] clk_mhz);
    logic [31:0] info;
    info = '0;
    info[INFO_VERSION_LSB  +: 8]  = version;
    info[INFO_NSCRATCH_LSB +: 8]  = nscratch;
    info[INFO_CLK_MHZ_LSB  +: 16] = clk_mhz;
    return info;
  endfunction

endpackage

// File: rtl/first_nios2_sysid_uptime.sv
// 64-bit free-running uptime counter with enable, synchronous clear and a
// snapshot register that captures the upper word when the lower word is read.
module first_nios2_sysid_uptime (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic        snap,
  output logic [31:0] lo,
  output logic [31:0] hi_shadow
);

  logic [63:0] count;

  // Counter: clear has priority over increment, wraps silently at 2^64
  always_ff @(posedge clock) begin
    if (reset)      count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= count + 64'd1;
  end

  // Upper word is frozen at the same edge the lower word is sampled so a
  // LO-then-HI read pair is coherent; clear leaves the shadow untouched
  always_ff @(posedge clock) begin
    if (reset)      hi_shadow <= '0;
    else if (snap)  hi_shadow <= count[63:32];
  end

  assign lo = count[31:0];

endmodule

// File: rtl/first_nios2_system_sysid_ext.sv
// Avalon-MM latency-1 sysid/housekeeping slave: ID, build timestamp, build
// info, counter control, snapshotted uptime counter and scratch words.
module first_nios2_system_sysid_ext
  import first_nios2_sysid_pkg::*;
#(
  parameter logic [31:0] ID          = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd1520954411,
  parameter logic [7:0]  VERSION     = 8'd2,
  parameter logic [15:0] CLK_MHZ     = 16'd50,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  // Keep at least one storage word so a zero-scratch build still elaborates
  localparam int unsigned SCRATCH_WORDS = (NUM_SCRATCH == 0) ? 1 : NUM_SCRATCH;
  localparam logic [31:0] INFO_WORD = pack_info(VERSION, 8'(NUM_SCRATCH), CLK_MHZ);

  logic [31:0] addr_i;
  logic        wr_ctrl;
  logic        cnt_en;
  logic        cnt_clr;
  logic        snap;
  logic [31:0] up_lo;
  logic [31:0] up_hi_shadow;
  logic [31:0] scratch [SCRATCH_WORDS];
  logic [31:0] rdata_next;

  assign addr_i  = 32'(address);
  assign wr_ctrl = write && (addr_i == CTRL_OFS) && byteenable[0];
  assign cnt_clr = wr_ctrl && writedata[CTRL_CNT_CLR_BIT];
  assign snap    = read && (addr_i == UPTIME_LO_OFS);

  first_nios2_sysid_uptime u_uptime (
    .clock     (clock),
    .reset     (reset),
    .en        (cnt_en),
    .clr       (cnt_clr),
    .snap      (snap),
    .lo        (up_lo),
    .hi_shadow (up_hi_shadow)
  );

  // CTRL.CNT_EN storage; CNT_CLR is a pulse and is not stored
  always_ff @(posedge clock) begin
    if (reset)        cnt_en <= 1'b1;
    else if (wr_ctrl) cnt_en <= writedata[CTRL_CNT_EN_BIT];
  end

  // Scratch words with per-byte write enables
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < SCRATCH_WORDS; i++) scratch[i] <= '0;
    end else if (write) begin
      for (int unsigned i = 0; i < SCRATCH_WORDS; i++) begin
        if (i < NUM_SCRATCH && addr_i == SCRATCH_BASE + i) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (byteenable[b]) scratch[i][8*b +: 8] <= writedata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read decode; unmapped addresses return zero
  always_comb begin
    rdata_next = '0;
    case (addr_i)
      SYSID_OFS:     rdata_next = ID;
      TSTAMP_OFS:    rdata_next = TIMESTAMP;
      INFO_OFS:      rdata_next = INFO_WORD;
      CTRL_OFS:      rdata_next[CTRL_CNT_EN_BIT] = cnt_en;
      UPTIME_LO_OFS: rdata_next = up_lo;
      UPTIME_HI_OFS: rdata_next = up_hi_shadow;
      default: begin
        for (int unsigned i = 0; i < SCRATCH_WORDS; i++) begin
          if (i < NUM_SCRATCH && addr_i == SCRATCH_BASE + i) rdata_next = scratch[i];
        end
      end
    endcase
  end

  // Registered read response; data holds between accesses
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rdata_next;
    end
  end

endmodule
